// File: rtl/mul32_arbiter_pkg.sv
// Shared types for the 32-bit multiplier arbiter: multiplier port structs,
// arbiter state encoding and index-width helper.
package mul32_arbiter_pkg;

  localparam int unsigned Mul32Width = 32;

  typedef struct packed {
    logic                  enable;
    logic [Mul32Width-1:0] x;
    logic [Mul32Width-1:0] y;
  } mul32_in_t;

  typedef struct packed {
    logic                  can_accept_cmd;
    logic                  data_ready;
    logic [Mul32Width-1:0] prod;
  } mul32_out_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mul_arb_state_e;

  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_arb_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant_i,
// wrapping modulo NumReq.
module mul_arb_rr_picker
  import mul32_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = rr_idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_valid_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic              any_o,
  output logic [NumReq-1:0] grant_oh_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    any_o       = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = IdxW'((32'(last_grant_i) + off) % NumReq);
      if (!any_o && req_valid_i[cand]) begin
        any_o            = 1'b1;
        grant_oh_o[cand] = 1'b1;
        grant_idx_o      = cand;
      end
    end
  end

endmodule

// File: rtl/mul32_arbiter.sv
// Shares one 32-bit multiplier between NumReq requesters, one operation at a
// time, round-robin; product returned to the owner as a one-cycle pulse.
module mul32_arbiter
  import mul32_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq*Mul32Width-1:0] req_x_i,
  input  logic [NumReq*Mul32Width-1:0] req_y_i,
  output logic [NumReq-1:0]            req_accept_o,
  output logic [NumReq-1:0]            resp_valid_o,
  output logic [Mul32Width-1:0]        resp_prod_o,
  output logic                         busy_o,
  output mul32_in_t                    mul_in_o,
  input  mul32_out_t                   mul_out_i
);

  localparam int unsigned IdxW = rr_idx_w(NumReq);

  mul_arb_state_e        state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [Mul32Width-1:0] x_q, x_d, y_q, y_d;
  logic [Mul32Width-1:0] prod_q, prod_d;

  logic              any;
  logic [NumReq-1:0] grant_oh;
  logic [IdxW-1:0]   grant_idx;
  logic [NumReq-1:0] accept, resp;

  mul_arb_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req_valid_i  (req_valid_i),
    .last_grant_i (last_grant_q),
    .any_o        (any),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NumReq - 1);
      x_q          <= '0;
      y_q          <= '0;
      prod_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      prod_q       <= prod_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    prod_d       = prod_q;
    accept       = '0;
    resp         = '0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          accept  = grant_oh;
          owner_d = grant_idx;
          x_d     = req_x_i[grant_idx*Mul32Width +: Mul32Width];
          y_d     = req_y_i[grant_idx*Mul32Width +: Mul32Width];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mul_out_i.can_accept_cmd) state_d = StWait;
      end
      // data_ready is only meaningful here; elsewhere it is ignored
      StWait: begin
        if (mul_out_i.data_ready) begin
          prod_d  = mul_out_i.prod;
          state_d = StResp;
        end
      end
      StResp: begin
        resp[owner_q] = 1'b1;
        last_grant_d  = owner_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while rst_i is high, independent of the state register.
  assign req_accept_o = rst_i ? '0 : accept;
  assign resp_valid_o = rst_i ? '0 : resp;
  assign resp_prod_o  = rst_i ? '0 : prod_q;
  assign busy_o       = !rst_i && (state_q != StIdle);

  always_comb begin
    mul_in_o        = '0;
    mul_in_o.enable = !rst_i && (state_q == StIssue);
    mul_in_o.x      = rst_i ? '0 : x_q;
    mul_in_o.y      = rst_i ? '0 : y_q;
  end

endmodule

// File: tb/tb_mul32_arbiter.sv
// Self-checking bench for mul32_arbiter with a behavioural fixed-latency
// multiplier and a round-robin reference model.
module tb_mul32_arbiter;
  import mul32_arbiter_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned Lat = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [31:0]    xs [N];
  logic [31:0]    ys [N];
  logic [N*32-1:0] req_x, req_y;
  logic [N-1:0]   req_accept, resp_valid;
  logic [31:0]    resp_prod;
  logic           busy;
  mul32_in_t      mul_in;
  mul32_out_t     mul_out;

  // Multiplier model state and controls
  int          stall_cfg  = 0;
  logic        spur_dr    = 1'b0;
  logic        pend       = 1'b0;
  int          cnt        = 0;
  int          stall_seen = 0;
  logic [31:0] prod_m     = '0;

  int total = 0;
  int bad   = 0;
  int last_g;

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < N; i++) begin
      req_x[i*32 +: 32] = xs[i];
      req_y[i*32 +: 32] = ys[i];
    end
  end

  assign mul_out.can_accept_cmd = (stall_seen >= stall_cfg);
  assign mul_out.data_ready     = (pend && cnt == 0) || spur_dr;
  assign mul_out.prod           = spur_dr ? 32'hDEAD_BEEF : prod_m;

  always @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      cnt        <= 0;
      stall_seen <= 0;
      prod_m     <= '0;
    end else begin
      if (pend) begin
        if (cnt == 0) pend <= 1'b0;
        else cnt <= cnt - 1;
      end
      if (mul_in.enable) begin
        if (mul_out.can_accept_cmd) begin
          pend       <= 1'b1;
          cnt        <= Lat - 1;
          prod_m     <= mul_in.x * mul_in.y;
          stall_seen <= 0;
        end else begin
          stall_seen <= stall_seen + 1;
        end
      end
    end
  end

  mul32_arbiter #(
    .NumReq (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_x_i      (req_x),
    .req_y_i      (req_y),
    .req_accept_o (req_accept),
    .resp_valid_o (resp_valid),
    .resp_prod_o  (resp_prod),
    .busy_o       (busy),
    .mul_in_o     (mul_in),
    .mul_out_i    (mul_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_accept"}, 32'(req_accept), 32'd0);
    check({tag, "_resp"}, 32'(resp_valid), 32'd0);
    check({tag, "_prod"}, resp_prod, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_en"}, 32'(mul_in.enable), 32'd0);
    check({tag, "_x"}, mul_in.x, 32'd0);
    check({tag, "_y"}, mul_in.y, 32'd0);
  endtask

  // One full transaction from the Idle cycle through the response pulse.
  task automatic op(input logic [N-1:0] mask, input int stall, input bit hold,
                    input bit spur, output int got);
    int          w;
    int          lat;
    logic [31:0] ex, ey, ep;
    logic [63:0] full;
    nxt();
    req_valid = mask;
    stall_cfg = stall;
    smp();
    w   = rr_pick(last_g, mask);
    got = -1;
    for (int i = 0; i < N; i++) if (req_accept[i]) got = i;
    check("accept", 32'(req_accept), 32'(1 << w));
    check("resp_gap", 32'(resp_valid), 32'd0);
    ex   = xs[w];
    ey   = ys[w];
    full = {32'd0, ex} * {32'd0, ey};
    ep   = full[31:0];
    for (int s = 0; s <= stall; s++) begin
      nxt();
      if (s == 0) begin
        if (!hold) req_valid[w] = 1'b0;
        xs[w]   = $urandom;
        ys[w]   = $urandom;
        spur_dr = spur;
      end else begin
        spur_dr = 1'b0;
      end
      smp();
      check("issue_en", 32'(mul_in.enable), 32'd1);
      check("issue_x", mul_in.x, ex);
      check("issue_y", mul_in.y, ey);
    end
    lat = 1 + stall;
    do begin
      nxt();
      spur_dr = 1'b0;
      smp();
      lat++;
      check("no_accept_busy", 32'(req_accept), 32'd0);
    end while (resp_valid === '0 && lat < 40);
    check("resp_lat", 32'(lat), 32'(2 + stall + Lat));
    check("resp_valid", 32'(resp_valid), 32'(1 << w));
    check("resp_prod", resp_prod, ep);
    check("hold_x", mul_in.x, ex);
    check("resp_en", 32'(mul_in.enable), 32'd0);
    last_g = w;
  endtask

  initial begin
    int got;
    for (int i = 0; i < N; i++) begin
      xs[i] = 32'd0;
      ys[i] = 32'd0;
    end

    // Reset with all requesters active: outputs must stay forced low
    rst       = 1'b1;
    req_valid = '1;
    nxt();
    nxt();
    smp();
    check_quiet("reset");
    nxt();
    rst       = 1'b0;
    req_valid = '0;
    last_g    = N - 1;
    smp();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single request, 7*6
    xs[0] = 32'd7;
    ys[0] = 32'd6;
    op(3'b001, 0, 1'b0, 1'b0, got);
    check("single_prod", resp_prod, 32'd42);

    // Spurious data_ready while Idle
    nxt();
    spur_dr = 1'b1;
    smp();
    check("spur_idle_resp", 32'(resp_valid), 32'd0);
    nxt();
    spur_dr = 1'b0;
    smp();
    check("spur_idle_busy", 32'(busy), 32'd0);
    check("spur_idle_resp2", 32'(resp_valid), 32'd0);
    check("prod_held", resp_prod, 32'd42);

    // Spurious data_ready while Issue, then the real product
    xs[1] = 32'd1234;
    ys[1] = 32'd5678;
    op(3'b010, 0, 1'b0, 1'b1, got);

    // Contention fairness with both requesters held
    xs[0] = 32'd3;
    ys[0] = 32'd5;
    xs[1] = 32'd11;
    ys[1] = 32'd13;
    last_g = 1;
    // Give requester 1 a grant first so the alternation starts at 0
    op(3'b010, 0, 1'b0, 1'b0, got);
    for (int i = 0; i < 4; i++) begin
      op(3'b011, 0, 1'b1, 1'b0, got);
      check("fair_order", 32'(got), 32'(i % 2));
    end

    // Issue stall of 4 cycles
    xs[2] = 32'h0001_0001;
    ys[2] = 32'h0000_FFFF;
    op(3'b100, 4, 1'b0, 1'b0, got);

    // Reset while Wait: pointer last at 0, so without reset requester 1 would win
    op(3'b001, 0, 1'b0, 1'b0, got);
    nxt();
    req_valid = 3'b010;
    smp();
    check("rw_accept", 32'(req_accept), 32'b010);
    nxt();
    req_valid = '0;
    smp();
    nxt();
    smp();
    check("rw_in_wait", 32'(busy), 32'd1);
    nxt();
    rst = 1'b1;
    smp();
    check_quiet("rst_wait");
    nxt();
    rst    = 1'b0;
    last_g = N - 1;
    smp();
    for (int i = 0; i < Lat + 3; i++) begin
      check("rw_no_resp", 32'(resp_valid), 32'd0);
      check("rw_idle", 32'(busy), 32'd0);
      nxt();
      smp();
    end
    op(3'b011, 0, 1'b0, 1'b0, got);
    check("rw_grant0", 32'(got), 32'd0);

    // Wrap and width
    xs[0] = 32'hFFFF_FFFF;
    ys[0] = 32'd2;
    op(3'b001, 0, 1'b0, 1'b0, got);
    check("wrap_prod", resp_prod, 32'hFFFF_FFFE);

    // Only requester 2 repeatedly, then 3-way contention goes to 0
    op(3'b100, 0, 1'b0, 1'b0, got);
    check("only2_a", 32'(got), 32'd2);
    op(3'b100, 1, 1'b0, 1'b0, got);
    check("only2_b", 32'(got), 32'd2);
    op(3'b111, 0, 1'b0, 1'b0, got);
    check("three_way", 32'(got), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom;
        ys[i] = $urandom;
      end
      op(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)), 1'b0,
         1'($urandom_range(0, 1)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul32_arbiter.md
# mul32_arbiter

- Shares one `Multiplier32` instance between `NUM_REQ` requesters, e.g. the execute stage and the address-generation unit.
- Accepts one request at a time, using round-robin arbitration.
- Drives the multiplier through the `PortIn_Multiplier32`/`PortOut_Multiplier32` handshake.
- Returns the 32-bit product to the winning requester as a one-cycle pulse.
- Sits between the requesters and the multiplier; it is the only master of the multiplier port.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: bit i is high while requester i holds a request.
- `req_x` in `NUM_REQ*32`: operand x; slice [32*i +: 32] belongs to requester i.
- `req_y` in `NUM_REQ*32`: operand y, sliced the same way.
- `req_accept` out `NUM_REQ`: one-hot pulse; the request and its operands were taken this cycle.
- `resp_valid` out `NUM_REQ`: one-hot pulse; `resp_prod` is valid for that requester this cycle.
- `resp_prod` out 32: product, shared by all requesters.
- `busy` out 1: high whenever the state is not Idle.
- `mul_in` out `PortIn_Multiplier32`: enable, x and y to the multiplier.
- `mul_out` in `PortOut_Multiplier32`: can_accept_cmd, data_ready and prod from the multiplier.

## Operation
The state machine has four states: Idle, Issue, Wait and Resp. Reset state is Idle.
- **Idle:**
  - If any `req_valid` bit is high, pick winner w by round-robin.
  - Assert `req_accept[w]` combinationally in this cycle.
  - Latch `req_x[w]`, `req_y[w]` and the owner w.
  - Go to Issue.
- **Issue:**
  - Drive `mul_in.enable`=1 with the latched x and y.
  - When `mul_out.can_accept_cmd`=1, go to Wait; otherwise hold in Issue.
- **Wait:**
  - `mul_in.enable`=0.
  - On `mul_out.data_ready`=1, register `mul_out.prod` into `resp_prod` and go to Resp.
- **Resp:**
  - `resp_valid[owner]`=1 for exactly one cycle.
  - Update the round-robin pointer to the owner.
  - Go to Idle.

Round-robin rules:
- Pointer `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first after reset.
- The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.

Boundary conditions:
- `data_ready` while in Idle or Issue is ignored; no stale product is delivered.
- `req_valid` dropped before it is accepted: no operation is started.
- Operands are sampled only in the accept cycle; changes after that have no effect.
- Requests arriving outside Idle are not accepted; requesters keep `req_valid` asserted.
- A requester may re-request in the cycle its `resp_valid` is high. It is considered in the following Idle cycle, with the pointer already advanced past it.
- `rst` mid-operation:
  - Return to Idle and reset the pointer; the in-flight result is discarded.
  - No `resp_valid` is issued for the discarded operation.
  - The multiplier shares `rst`.
- `mul_in.x` and `mul_in.y` hold the latched operands outside Issue; they are not zeroed.

## Timing
Reset values, held while `rst`=1 and forced to 0 regardless of combinational paths:
- `req_accept`=0, `resp_valid`=0, `resp_prod`=0, `busy`=0, `mul_in`=0.

Latency and throughput:
- Accept at cycle A.
- `mul_in.enable` at A+1; it is accepted at A+1+S, where S is the number of stall cycles with `can_accept_cmd`=0.
- `data_ready` arrives at A+1+S+L, where L is the multiplier latency.
- `resp_valid` at A+2+S+L.
- Earliest next accept is A+3+S+L, giving one operation per L+S+3 cycles.

Output behaviour:
- `resp_prod` holds its value until the next Resp.
- `resp_prod` carries the low 32 bits of the product only; signedness is irrelevant.

## Structure
Additions to `PkgAlu`:
- `MulArbState` enum: Idle, Issue, Wait, Resp.
- `MUL32_WIDTH` constant = 32.

Sub-modules:
- `mul_arb_rr_picker`: combinational; inputs `req_valid` and `last_grant`; outputs `any` and the one-hot/index winner.
- The arbiter instantiates it once; the multiplier itself is instantiated outside this block.

## Test plan
- **Single request, L=3, no stall:**
  - Stimulus: reset, then `req_valid`=01, x=7, y=6.
  - `req_accept`=01 at A; enable at A+1; `resp_valid`=01 with `resp_prod`=42 at A+5.
- **Contention fairness:**
  - Stimulus: `req_valid`=11 held permanently, with distinct operands per requester.
  - Grants alternate 0,1,0,1; each `resp_prod` matches its owner's x*y.
- **Issue stall:**
  - Stimulus: `can_accept_cmd`=0 for 4 cycles.
  - Arbiter holds in Issue with enable=1 and stable operands; `resp_valid` is 4 cycles later than in the no-stall case.
- **Spurious data_ready:**
  - Stimulus: `data_ready` pulse while in Idle and while in Issue.
  - No `resp_valid`; the later real product is delivered correctly.
- **Reset mid-Wait:**
  - Stimulus: `rst` for 1 cycle while in Wait.
  - All outputs are 0 and there is no `resp_valid`; the next contended grant goes to requester 0.
- **Wrap and width:**
  - Stimulus: x=0xFFFFFFFF, y=2.
  - `resp_prod`=0xFFFFFFFE.
  - With `NUM_REQ`=3 and only requester 2 requesting, grants to 2 repeat; after a grant to 2, a 3-way contention is won by 0.
